// File: rtl/rs_pipe_adder.sv
// rs_pipe_adder: segmented carry-pipelined adder/subtractor with a valid/ready
// stream interface. Each stage adds one SEG_WIDTH slice, using the carry that
// the previous stage registered. The whole pipe advances in lockstep whenever
// the output slot is empty or is being consumed.
module rs_pipe_adder #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output logic             ovf
);

    localparam int NSEG   = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
    localparam int LAST_W = WIDTH - (NSEG - 1) * SEG_WIDTH;

    // Global advance: every stage shifts together, so one bit stalls the pipe.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage k consumes bits [LO +: SW] of the operands. It receives the
    // operand bits that are still to be added (RW wide) and the sum bits
    // already finished (LO wide), and registers DW finished sum bits.
    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO = k * SEG_WIDTH;
        localparam int SW = (k == NSEG - 1) ? LAST_W : SEG_WIDTH;
        localparam int RW = WIDTH - LO;
        localparam int DW = LO + SW;

        logic [RW-1:0] a_in;
        logic [RW-1:0] bb_in;
        logic          c_in;
        logic          v_in;
        logic [SW:0]   seg_add;
        logic [DW-1:0] sum_d;

        logic          v_q;
        logic          c_q;
        logic [DW-1:0] sum_q;

        // Stage input: the port for stage 0, otherwise the previous stage.
        if (k == 0) begin : g_src
            assign a_in  = a;
            assign bb_in = sub ? ~b : b;
            assign c_in  = ci;
            assign v_in  = in_valid;
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_tail.a_q;
            assign bb_in = g_stage[k-1].g_tail.bb_q;
            assign c_in  = g_stage[k-1].c_q;
            assign v_in  = g_stage[k-1].v_q;
        end

        // One segment of the ripple add; the top bit is this segment's carry.
        assign seg_add = {1'b0, a_in[SW-1:0]} + {1'b0, bb_in[SW-1:0]} + {{SW{1'b0}}, c_in};

        // Append the new segment above the sum bits finished so far.
        if (k == 0) begin : g_sum
            assign sum_d = seg_add[SW-1:0];
        end else begin : g_sum
            assign sum_d = {seg_add[SW-1:0], g_stage[k-1].sum_q};
        end

        // Valid flag, segment carry and finished sum bits; reset wins over advance.
        // NOTE: sequential state uses non-blocking assignments so all stages
        // sample the previous stage's old value on the same edge.
        always_ff @(posedge clk) begin
            if (reset) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q   <= v_in;
                c_q   <= seg_add[SW];
                sum_q <= sum_d;
            end
        end

        if (k < NSEG - 1) begin : g_tail
            logic [RW-SW-1:0] a_q;
            logic [RW-SW-1:0] bb_q;

            // Delay the not-yet-added operand bits alongside the partial sum.
            // NOTE: operand registers carry no reset; a stale value only ever
            // travels next to a cleared valid flag and never reaches y.
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_q  <= a_in[RW-1:SW];
                    bb_q <= bb_in[RW-1:SW];
                end
            end
        end else begin : g_msb
            logic ovf_q;
            logic carry_into_msb;

            // Carry into the MSB is recovered from the MSB's own sum bit.
            assign carry_into_msb = a_in[SW-1] ^ bb_in[SW-1] ^ seg_add[SW-1];

            // Signed overflow flag, registered with the final segment.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= carry_into_msb ^ seg_add[SW];
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].v_q;
    assign y         = g_stage[NSEG-1].sum_q;
    assign co        = g_stage[NSEG-1].c_q;
    assign ovf       = g_stage[NSEG-1].g_msb.ovf_q;

endmodule

// File: tb/tb_rs_pipe_adder.sv
// Testbench for rs_pipe_adder: directed vector table on a 16-bit / 4-segment
// instance, stall/order stream, mid-flight reset, and a segment-width sweep.
module tb_rs_pipe_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        co;
    logic        ovf;

    // Shared stimulus for the sweep instances (never stalled downstream).
    logic        sw_valid;
    logic [15:0] sw_a;
    logic [15:0] sw_b;
    logic        sw_ci;
    logic        sw_sub;
    logic        s1_in_ready,  s3_in_ready,  s16_in_ready;
    logic        s1_valid,     s3_valid,     s16_valid;
    logic [15:0] s1_y,         s3_y,         s16_y;
    logic        s1_co,        s3_co,        s16_co;
    logic        s1_ovf,       s3_ovf,       s16_ovf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rs_pipe_adder #(.WIDTH(16), .SEG_WIDTH(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .co(co), .ovf(ovf)
    );

    rs_pipe_adder #(.WIDTH(16), .SEG_WIDTH(1)) u_s1 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(s1_in_ready),
        .a(sw_a), .b(sw_b), .ci(sw_ci), .sub(sw_sub), .out_valid(s1_valid),
        .out_ready(1'b1), .y(s1_y), .co(s1_co), .ovf(s1_ovf)
    );

    rs_pipe_adder #(.WIDTH(16), .SEG_WIDTH(3)) u_s3 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(s3_in_ready),
        .a(sw_a), .b(sw_b), .ci(sw_ci), .sub(sw_sub), .out_valid(s3_valid),
        .out_ready(1'b1), .y(s3_y), .co(s3_co), .ovf(s3_ovf)
    );

    rs_pipe_adder #(.WIDTH(16), .SEG_WIDTH(16)) u_s16 (
        .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(s16_in_ready),
        .a(sw_a), .b(sw_b), .ci(sw_ci), .sub(sw_sub), .out_valid(s16_valid),
        .out_ready(1'b1), .y(s16_y), .co(s16_co), .ovf(s16_ovf)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] y;
        logic        co;
        logic        ovf;
    } vec_t;

    // Reference: {ovf, co, y}; overflow from the carry into bit 15 vs carry out.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mci, input logic msub);
        logic [15:0] bb;
        logic [16:0] s;
        logic [15:0] low;
        bb  = msub ? ~mb : mb;
        s   = {1'b0, ma} + {1'b0, bb} + {16'd0, mci};
        low = {1'b0, ma[14:0]} + {1'b0, bb[14:0]} + {15'd0, mci};
        return {low[15] ^ s[16], s[16], s[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl [11];
    logic [17:0] exp_q [$];
    logic [17:0] q1 [$];
    logic [17:0] q3 [$];
    logic [17:0] q16 [$];

    initial begin
        int          lat;
        int          sent;
        int          got;
        int          seen;
        int          lat1, lat3, lat16;
        logic        stalled;
        logic [17:0] held;
        logic [17:0] m;

        tbl[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[6]  = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        tbl[7]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[8]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[9]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[10] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0;
        tick(); tick(); tick();
        reset = 1'b0;

        // Reset state, first cycle after reset deasserts.
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_y",         32'(y),         32'd0);
        check("rst_co",        32'(co),        32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_sw_ready",  32'({s1_in_ready, s3_in_ready, s16_in_ready}), 32'h7);

        // Directed table: single beats, latency and value of each.
        for (int i = 0; i < 11; i++) begin
            a = tbl[i].a; b = tbl[i].b; ci = tbl[i].ci; sub = tbl[i].sub;
            in_valid = 1'b1;
            check("tbl_in_ready", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("tbl_latency", 32'(lat), 32'd4);
            check("tbl_y",   32'(y),   32'(tbl[i].y));
            check("tbl_co",  32'(co),  32'(tbl[i].co));
            check("tbl_ovf", 32'(ovf), 32'(tbl[i].ovf));
            tick();
        end

        // Back-to-back beats with a randomly stalling sink.
        sent = 0; got = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 8) begin
                in_valid = 1'b1;
                a   = 16'h1F3D * 16'(sent + 1);
                b   = 16'hC0A7 ^ 16'(sent * 16'h1111);
                ci  = sent[0];
                sub = sent[1];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                check("stream_in_ready", 32'(in_ready), 32'(out_ready));
                if (stalled) check("stream_hold", 32'({ovf, co, y}), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    m = exp_q.pop_front();
                    check("stream_result", 32'({ovf, co, y}), 32'(m));
                end else begin
                    check("stream_unexpected", 32'(exp_q.size()), 32'd1);
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = {ovf, co, y};
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, ci, sub));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_count", 32'(got), 32'd8);
        tick(); tick(); tick(); tick(); tick();

        // Reset with three beats in flight and a fourth offered in the reset cycle.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'h1111 * 16'(i + 1); b = 16'h0F0F; ci = 1'b1; sub = 1'b0;
            tick();
        end
        check("pre_rst_out_valid", 32'(out_valid), 32'd0);
        a = 16'hAAAA; b = 16'h5555;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_y",         32'(y),         32'd0);
        check("mid_rst_co_ovf",    32'({co, ovf}), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_rst_no_ghost", 32'(seen), 32'd0);

        // Sweep: latency for SEG_WIDTH 1, 3, 16.
        sw_a = 16'h00FF; sw_b = 16'h0001; sw_ci = 1'b0; sw_sub = 1'b0;
        sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0;
        lat1 = 0; lat3 = 0; lat16 = 0;
        for (int c = 1; c <= 30; c++) begin
            if (s1_valid  && lat1  == 0) lat1  = c;
            if (s3_valid  && lat3  == 0) lat3  = c;
            if (s16_valid && lat16 == 0) lat16 = c;
            tick();
        end
        check("sweep_lat_seg1",  32'(lat1),  32'd16);
        check("sweep_lat_seg3",  32'(lat3),  32'd6);
        check("sweep_lat_seg16", 32'(lat16), 32'd1);

        // Sweep: 1000 random vectors through each width, scoreboarded in order.
        for (int n = 0; n < 1020; n++) begin
            if (s1_valid) begin
                if (q1.size() > 0) begin
                    m = q1.pop_front();
                    check("sweep1_result", 32'({s1_ovf, s1_co, s1_y}), 32'(m));
                end else check("sweep1_unexpected", 32'(q1.size()), 32'd1);
            end
            if (s3_valid) begin
                if (q3.size() > 0) begin
                    m = q3.pop_front();
                    check("sweep3_result", 32'({s3_ovf, s3_co, s3_y}), 32'(m));
                end else check("sweep3_unexpected", 32'(q3.size()), 32'd1);
            end
            if (s16_valid) begin
                if (q16.size() > 0) begin
                    m = q16.pop_front();
                    check("sweep16_result", 32'({s16_ovf, s16_co, s16_y}), 32'(m));
                end else check("sweep16_unexpected", 32'(q16.size()), 32'd1);
            end
            if (n < 1000) begin
                sw_valid = 1'b1;
                sw_a   = 16'($urandom);
                sw_b   = 16'($urandom);
                sw_ci  = 1'($urandom_range(0, 1));
                sw_sub = 1'($urandom_range(0, 1));
                m = model(sw_a, sw_b, sw_ci, sw_sub);
                q1.push_back(m);
                q3.push_back(m);
                q16.push_back(m);
            end else begin
                sw_valid = 1'b0;
            end
            tick();
        end
        check("sweep1_drained",  32'(q1.size()),  32'd0);
        check("sweep3_drained",  32'(q3.size()),  32'd0);
        check("sweep16_drained", 32'(q16.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rs_pipe_adder.md
RS_PIPE_ADDER -- requirements
Module: rs_pipe_adder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 32: operand/result width, legal range 3..256.
REQ-003 Parameter SEG_WIDTH, default 8: carry-chain segment width, legal range 1..WIDTH.
REQ-004 Derived constant NSEG SHALL equal ceil(WIDTH/SEG_WIDTH); LAST_W SHALL equal WIDTH-(NSEG-1)*SEG_WIDTH.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operand beat offered.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 ci  input  1  carry-in.
REQ-012 sub  input  1  invert B before adding (BI).
REQ-013 out_valid  output  1  result beat present.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 y  output  WIDTH  sum.
REQ-016 co  output  1  carry out of bit WIDTH-1.
REQ-017 ovf  output  1  two's-complement overflow.

Function
REQ-018 Effective operand: bb = sub ? ~b : b; result SHALL be y = (a + bb + ci) mod 2^WIDTH; carry-in is never implied by sub.
REQ-019 co SHALL be bit WIDTH of a + bb + ci; ovf SHALL be carry-into-MSB XOR carry-out-of-MSB.
REQ-020 Datapath SHALL be NSEG pipeline stages; stage k adds segment k (bits k*SEG_WIDTH upward, LAST_W bits for k=NSEG-1) using the carry registered by stage k-1 (stage 0 uses ci).
REQ-021 Operand bits for segments not yet added SHALL be delayed alongside; completed sum bits SHALL be carried forward so y emerges aligned.
REQ-022 Each stage SHALL hold a valid flag; empty stages are bubbles and SHALL NOT produce out_valid.
REQ-023 Global advance signal adv = ~out_valid | out_ready; in_ready SHALL equal adv.
REQ-024 A beat is accepted when in_valid & in_ready; a result is consumed when out_valid & out_ready.
REQ-025 When adv=1 every stage SHALL shift one position; when adv=0 all stage registers, valid flags and outputs SHALL hold.
REQ-026 Latency SHALL be exactly NSEG cycles from acceptance to out_valid with no stall; throughput one beat per cycle.
REQ-027 NSEG=1 (SEG_WIDTH>=WIDTH) SHALL give a single registered stage, latency 1.
REQ-028 y, co, ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 Results SHALL emerge in acceptance order with no loss or duplication.
REQ-030 in_valid while in_ready=0 SHALL NOT be captured; the source holds the beat.
REQ-031 Simultaneous accept and consume in one cycle SHALL be supported without a bubble.

Reset
REQ-032 On reset=1 at a clock edge all stage valid flags and out_valid SHALL clear to 0.
REQ-033 y, co, ovf SHALL reset to 0; data registers in stages may otherwise be unreset.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-035 Reset mid-operation SHALL discard all in-flight beats; none SHALL later appear.
REQ-036 Reset SHALL take priority over accept and advance in the same cycle.

Verification (WIDTH=16, SEG_WIDTH=4, NSEG=4, out_ready=1 unless stated)
REQ-037 a=0x00FF, b=0x0001, ci=0, sub=0 -> 4 cycles later out_valid=1, y=0x0100, co=0, ovf=0.
REQ-038 a=0xFFFF, b=0x0001, ci=0, sub=0 -> y=0x0000, co=1, ovf=0 (carry ripples through all four registered segments).
REQ-039 a=0x0005, b=0x0007, ci=1, sub=1 -> y=0xFFFE, co=0, ovf=0; a=0x7FFF, b=0x0001, ci=0, sub=0 -> y=0x8000, co=0, ovf=1.
REQ-040 Eight back-to-back beats with out_ready toggled pseudo-randomly -> eight results in order, each held stable while stalled, in_ready=out_ready whenever out_valid=1.
REQ-041 Reset asserted for one cycle with three beats in flight -> next cycle out_valid=0, in_ready=1, y=0; none of the three results ever emerges.
REQ-042 Parameter sweep SEG_WIDTH in {1,3,16}, WIDTH=16 -> latency 16, 6, 1 respectively; results match REQ-018/019 on 1000 random vectors.
